// File: rtl/muldiv_seq_if.sv
// Request/response bundle between decode (master) and the multiply/divide sequencer (slave).
// The div0 signal exists only when MULDIV_DIV0_FLAG_EN is defined.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             kill;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] rdata;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0;
`endif

    modport master (
        output op_valid, op, op1, op2, kill,
`ifdef MULDIV_DIV0_FLAG_EN
        input  div0,
`endif
        input  stall, busy, rdata
    );

    modport slave (
        input  op_valid, op, op1, op2, kill,
`ifdef MULDIV_DIV0_FLAG_EN
        output div0,
`endif
        output stall, busy, rdata
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one shift-add or restoring step per cycle.
// Optional divide-by-zero pulse output bus.div0 when MULDIV_DIV0_FLAG_EN is defined.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_raw;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_stall;
    logic               w_accept;
    logic               w_start;
    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_rdata;

    assign w_stall  = ~rst & bus.op_valid & (r_state != S_IDLE);
    assign w_accept = bus.op_valid & ~w_stall & ~bus.kill;
    assign w_start  = w_accept & ~bus.op[2];

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign w_s1   = ~bus.op[0] & bus.op1[WIDTH-1];
    assign w_s2   = ~bus.op[0] & bus.op2[WIDTH-1];
    assign w_abs1 = w_s1 ? -bus.op1 : bus.op1;
    assign w_abs2 = w_s2 ? -bus.op2 : bus.op2;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder stays below the divisor, so the difference always fits in WIDTH bits
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_step = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.kill) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_next = S_RUN;
                S_RUN:   if (r_count == CW'(WIDTH-1)) w_state_next = S_FIX;
                S_FIX:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_raw    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            if (bus.kill) begin
                r_count <= '0;
            end else if (w_start) begin
                r_count  <= '0;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_s1 ^ w_s2;
                r_neg_r  <= w_s1;
                r_div0   <= (bus.op2 == '0);
                r_raw    <= bus.op1;
                r_b      <= bus.op[1] ? w_abs2 : w_abs1;
                r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs1 : w_abs2)};
            end else if (r_state == S_RUN) begin
                r_count <= r_count + 1'b1;
                r_acc   <= r_is_div ? w_div_step : w_mul_step;
            end

            if (r_state == S_FIX && !bus.kill) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_div0) begin
                    r_hi <= r_raw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end else if (w_accept && bus.op == 3'b110) begin
                r_hi <= bus.op1;
            end else if (w_accept && bus.op == 3'b111) begin
                r_lo <= bus.op1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (!rst && bus.op_valid && r_state == S_IDLE) begin
            if (bus.op == 3'b100) w_rdata = r_hi;
            if (bus.op == 3'b101) w_rdata = r_lo;
        end
    end

    assign bus.stall = w_stall;
    assign bus.busy  = r_busy;
    assign bus.rdata = w_rdata;

`ifdef MULDIV_DIV0_FLAG_EN
    logic r_div0_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div0_flag <= 1'b0;
        end else begin
            r_div0_flag <= (r_state == S_FIX) & ~bus.kill & r_is_div & r_div0;
        end
    end

    assign bus.div0 = r_div0_flag;
`endif
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO pushed when an op is driven, popped on MFHI/MFLO.
// Also covers stall hold, kill, reset mid-run and (when MULDIV_DIV0_FLAG_EN is defined) div0.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference results {HI, LO} from native 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        int     sa;
        int     sb;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        sa = a;
        sb = b;
        p  = '0;
        case (op)
            3'd0: p = la * lb;
            3'd1: p = {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0)                                  p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else                                             p = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = {m_hi, m_lo};
        endcase
        return p;
    endfunction

    task automatic drive_idle();
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.op1      = '0;
        bus.op2      = '0;
        bus.kill     = 1'b0;
    endtask

    task automatic read_hilo(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        exp = sb_q.pop_front();
        bus.op_valid = 1'b0;
        #1;
        check_val({tag, "_rdata_idle"}, bus.rdata, 64'd0);
        bus.op_valid = 1'b1;
        bus.op       = 3'd4;
        #1;
        check_val({tag, "_mf_stall"}, bus.stall, 64'd0);
        check_val({tag, "_hi"}, bus.rdata, exp[63:32]);
        bus.op = 3'd5;
        #1;
        check_val({tag, "_lo"}, bus.rdata, exp[31:0]);
        $display("read %s: hi=%08h lo=%08h", tag, exp[63:32], exp[31:0]);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          n;
        int          d0;
        exp = model(op, a, b);
        {m_hi, m_lo} = exp;
        sb_q.push_back(exp);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.op1      = a;
        bus.op2      = b;
        #1;
        check_val("issue_stall", bus.stall, 64'd0);
        @(posedge clk);
        #1;
        drive_idle();
        n  = 0;
        d0 = 0;
        while (bus.busy && n < 100) begin
            n++;
`ifdef MULDIV_DIV0_FLAG_EN
            if (bus.div0) d0++;
`endif
            @(posedge clk);
            #1;
        end
        check_val("busy_cycles", n, 64'd33);
`ifdef MULDIV_DIV0_FLAG_EN
        if (bus.div0) d0++;
        check_val("div0_pulse", d0, {63'd0, (op[1] && b == 32'h0)});
`else
        d0 = 0;
`endif
        $display("op=%0d a=%08h b=%08h busy=%0d expect hi=%08h lo=%08h", op, a, b, n, exp[63:32], exp[31:0]);
        read_hilo("arith");
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] val);
        if (op == 3'd6) m_hi = val;
        else            m_lo = val;
        sb_q.push_back({m_hi, m_lo});
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.op1      = val;
        @(posedge clk);
        #1;
        drive_idle();
        $display("move op=%0d val=%08h", op, val);
        read_hilo("move");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        rst = 1'b1;
        drive_idle();
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = 3'd5;
        #1;
        check_val("rst_stall", bus.stall, 64'd0);
        check_val("rst_rdata", bus.rdata, 64'd0);
        check_val("rst_busy", bus.busy, 64'd0);
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
        sb_q.push_back({m_hi, m_lo});
        read_hilo("reset");

        run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_arith(3'd0, 32'hFFFF_FFFD, 32'd7);
        run_arith(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_arith(3'd3, 32'd7, 32'd2);
        run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_arith(3'd3, 32'd5, 32'd0);
        run_arith(3'd2, 32'hFFFF_FFF0, 32'd0);
        run_arith(3'd2, 32'd100, 32'hFFFF_FFF9);

        // MFLO held while an operation is in flight
        exp = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        {m_hi, m_lo} = exp;
        bus.op_valid = 1'b1;
        bus.op       = 3'd1;
        bus.op1      = 32'h1234_5678;
        bus.op2      = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.op = 3'd5;
        #1;
        n = 0;
        while (bus.busy && n < 100) begin
            check_val("held_stall", bus.stall, 64'd1);
            n++;
            @(posedge clk);
            #2;
        end
        check_val("held_busy_cycles", n, 64'd33);
        check_val("held_release_stall", bus.stall, 64'd0);
        check_val("held_lo", bus.rdata, exp[31:0]);
        $display("held MFLO released after %0d cycles rdata=%08h", n, bus.rdata);
        @(posedge clk);
        #1;
        drive_idle();

        // kill in cycle 10 of a DIV after MTHI 0x1234
        move_to(3'd6, 32'h0000_1234);
        move_to(3'd7, 32'h0000_ABCD);
        bus.op_valid = 1'b1;
        bus.op       = 3'd2;
        bus.op1      = 32'd100;
        bus.op2      = 32'd3;
        @(posedge clk);
        #1;
        drive_idle();
        repeat (9) @(posedge clk);
        #1;
        check_val("kill_busy_before", bus.busy, 64'd1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check_val("kill_busy_after", bus.busy, 64'd0);
        $display("kill issued during DIV");
        sb_q.push_back({m_hi, m_lo});
        read_hilo("kill");

        // op presented together with kill is dropped
        bus.op_valid = 1'b1;
        bus.op       = 3'd6;
        bus.op1      = 32'hDEAD_BEEF;
        bus.kill     = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        sb_q.push_back({m_hi, m_lo});
        read_hilo("kill_drop");
        run_arith(3'd0, 32'd6, 32'hFFFF_FFFE);

        // reset during RUN
        bus.op_valid = 1'b1;
        bus.op       = 3'd1;
        bus.op1      = 32'hFFFF_FFFF;
        bus.op2      = 32'd3;
        @(posedge clk);
        #1;
        drive_idle();
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_busy", bus.busy, 64'd0);
        m_hi = '0;
        m_lo = '0;
        $display("reset asserted during RUN");
        sb_q.push_back({m_hi, m_lo});
        read_hilo("midrst");

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(1, 9));
            if (i % 5 == 4) rb = 32'h0;
            if (i % 4 == 1) ra = 32'($urandom_range(0, 1000));
            run_arith(rop, ra, rb);
        end

        check_val("sb_drained", sb_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
